// File: rtl/vga_sync_generator.sv
// Registered VGA sync/region decoder behind the h/v counters: two-stage pipeline plus vertical-region FSM.
// Optional feature macro VGA_FRAME_COUNT_EN builds an 8-bit frame counter; otherwise frame_count is 0.
module vga_sync_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk_div,
    input  logic        rst_n,
    input  logic [15:0] horizontal_count,
    input  logic [15:0] vertical_count,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_start,
    output logic        frame_start,
    output logic [1:0]  v_state,
    output logic        count_error,
    output logic [7:0]  frame_count
);
    localparam logic [15:0] H_TOTAL      = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] H_VIS        = 16'(H_ACTIVE);
    localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] V_TOTAL      = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] V_VIS        = 16'(V_ACTIVE);
    localparam logic [15:0] V_SYNC_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } vstate_t;

    function automatic vstate_t region_of(input logic [15:0] v);
        vstate_t s;
        if (v < V_VIS)             s = ST_ACTIVE;
        else if (v < V_SYNC_START) s = ST_FRONT;
        else if (v < V_SYNC_END)   s = ST_SYNC;
        else                       s = ST_BACK;
        return s;
    endfunction

    function automatic vstate_t region_after(input vstate_t s);
        vstate_t n;
        case (s)
            ST_ACTIVE: n = ST_FRONT;
            ST_FRONT:  n = ST_SYNC;
            ST_SYNC:   n = ST_BACK;
            default:   n = ST_ACTIVE;
        endcase
        return n;
    endfunction

    // Stage-1 decode of the raw counts
    logic       w_oor, w_hs_on, w_vs_on, w_vid, w_line, w_frame;
    logic [9:0] w_px, w_py;

    assign w_oor   = (horizontal_count >= H_TOTAL) || (vertical_count >= V_TOTAL);
    assign w_hs_on = !w_oor && (horizontal_count >= H_SYNC_START) && (horizontal_count < H_SYNC_END);
    assign w_vs_on = !w_oor && (vertical_count >= V_SYNC_START) && (vertical_count < V_SYNC_END);
    assign w_vid   = !w_oor && (horizontal_count < H_VIS) && (vertical_count < V_VIS);
    assign w_line  = !w_oor && (horizontal_count == '0) && (vertical_count < V_VIS);
    assign w_frame = !w_oor && (horizontal_count == '0) && (vertical_count == '0);
    assign w_px    = w_vid ? horizontal_count[9:0] : '0;
    assign w_py    = w_vid ? vertical_count[9:0] : '0;

    logic        r_oor, r_hs_on, r_vs_on, r_vid, r_line, r_frame;
    logic [9:0]  r_px, r_py;
    logic [15:0] r_v, r_v_prev;
    logic        r_synced;
    vstate_t     r_state;

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_oor   <= 1'b0;
            r_hs_on <= 1'b0;
            r_vs_on <= 1'b0;
            r_vid   <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_v     <= '0;
        end else begin
            r_oor   <= w_oor;
            r_hs_on <= w_hs_on;
            r_vs_on <= w_vs_on;
            r_vid   <= w_vid;
            r_line  <= w_line;
            r_frame <= w_frame;
            r_px    <= w_px;
            r_py    <= w_py;
            r_v     <= vertical_count;
        end
    end

    // Vertical FSM: the previous v only tracks in-range counts, so an out-of-range burst is not a jump
    vstate_t w_state_next;
    vstate_t w_region;
    logic    w_v_step, w_v_changed, w_err;

    assign w_region = region_of(r_v);
    assign w_v_step = (r_v == r_v_prev + 16'd1) || ((r_v_prev == V_TOTAL - 16'd1) && (r_v == '0));

    always_comb begin
        w_state_next = r_state;
        w_v_changed  = 1'b0;
        w_err        = 1'b0;
        if (r_oor) begin
            w_err = 1'b1;
        end else if (r_v != r_v_prev) begin
            w_v_changed  = 1'b1;
            w_state_next = w_region;
            // The first line change after reset resyncs silently
            if (r_synced && !(w_v_step && ((w_region == r_state) || (w_region == region_after(r_state)))))
                w_err = 1'b1;
        end
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ACTIVE;
            r_v_prev <= '0;
            r_synced <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (!r_oor)
                r_v_prev <= r_v;
            if (w_v_changed)
                r_synced <= 1'b1;
        end
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            count_error <= 1'b0;
        end else begin
            hsync       <= r_hs_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= r_vs_on ? SYNC_POL : ~SYNC_POL;
            video_on    <= r_vid;
            pixel_x     <= r_px;
            pixel_y     <= r_py;
            line_start  <= r_line;
            frame_start <= r_frame;
            count_error <= w_err;
        end
    end

    assign v_state = r_state;

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n)
            r_frame_count <= '0;
        else if (r_frame)
            r_frame_count <= r_frame_count + 8'd1;
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Self-checking bench for vga_sync_generator: directed vector table, reset sequences,
// sparse/full-line frame sweeps and randomized counts against a behavioural model.
`timescale 1ns/1ps
module tb_vga_sync_generator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] h_in, v_in;
    logic        hsync, vsync, video_on, line_start, frame_start, count_error;
    logic [9:0]  pixel_x, pixel_y;
    logic [1:0]  v_state;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    vga_sync_generator dut (
        .clk_div          (clk),
        .rst_n            (rst_n),
        .horizontal_count (h_in),
        .vertical_count   (v_in),
        .hsync            (hsync),
        .vsync            (vsync),
        .video_on         (video_on),
        .pixel_x          (pixel_x),
        .pixel_y          (pixel_y),
        .line_start       (line_start),
        .frame_start      (frame_start),
        .v_state          (v_state),
        .count_error      (count_error),
        .frame_count      (frame_count)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vid;
        logic [9:0] px;
        logic [9:0] py;
        logic       ls;
        logic       fs;
        logic [1:0] st;
        logic       err;
        logic [7:0] fc;
    } outs_t;

    typedef struct {
        int    h;
        int    v;
        outs_t exp;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    outs_t exp_q[$];

    int m_last_v;
    bit m_synced;
    int m_state;
    int m_frames;

    function automatic outs_t reset_outs();
        outs_t o;
        o    = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic int region(input int v);
        if (v < 480) return 0;
        if (v < 490) return 1;
        if (v < 492) return 2;
        return 3;
    endfunction

    function automatic void model_reset();
        m_last_v = 0;
        m_synced = 1'b0;
        m_state  = 0;
        m_frames = 0;
    endfunction

    // Expected outputs for one input pair, advancing the model's vertical history
    function automatic outs_t model_step(input int h, input int v);
        outs_t o;
        o = reset_outs();
        if (h >= 800 || v >= 525) begin
            o.err = 1'b1;
        end else begin
            if (v != m_last_v) begin
                if (m_synced && v != (m_last_v + 1) % 525) o.err = 1'b1;
                m_synced = 1'b1;
                m_last_v = v;
                m_state  = region(v);
            end
            o.hs  = (h >= 656 && h < 752) ? 1'b0 : 1'b1;
            o.vs  = (v >= 490 && v < 492) ? 1'b0 : 1'b1;
            o.vid = (h < 640 && v < 480);
            o.px  = o.vid ? 10'(h) : 10'd0;
            o.py  = o.vid ? 10'(v) : 10'd0;
            o.ls  = (h == 0 && v < 480);
            o.fs  = (h == 0 && v == 0);
            if (o.fs) m_frames++;
        end
        o.st = 2'(m_state);
`ifdef VGA_FRAME_COUNT_EN
        o.fc = 8'(m_frames % 256);
`else
        o.fc = 8'd0;
`endif
        return o;
    endfunction

    task automatic check(input string name, input outs_t e);
        outs_t a;
        a = {hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, v_state, count_error, frame_count};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: actual hs=%b vs=%b vid=%b px=%0d py=%0d ls=%b fs=%b st=%0d err=%b fc=%0d | required hs=%b vs=%b vid=%b px=%0d py=%0d ls=%b fs=%b st=%0d err=%b fc=%0d",
                     name, $time, a.hs, a.vs, a.vid, a.px, a.py, a.ls, a.fs, a.st, a.err, a.fc,
                     e.hs, e.vs, e.vid, e.px, e.py, e.ls, e.fs, e.st, e.err, e.fc);
        end
    endtask

    // Called at a negedge: drive counts, check the output due for the previous input, return at negedge
    task automatic step(input int h, input int v, input string name, input bit use_tab, input outs_t tab_exp);
        outs_t e;
        outs_t due;
        h_in = 16'(h);
        v_in = 16'(v);
        e    = model_step(h, v);
        if (use_tab) begin
            tab_exp.fc = e.fc;
            e = tab_exp;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        due = exp_q.pop_front();
        check(name, due);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input int h, input int v, input bit hs, input bit vs, input bit vid,
                                input int px, input int py, input bit ls, input bit fs, input int st, input bit err);
        vec_t t;
        t.h       = h;
        t.v       = v;
        t.exp.hs  = hs;
        t.exp.vs  = vs;
        t.exp.vid = vid;
        t.exp.px  = 10'(px);
        t.exp.py  = 10'(py);
        t.exp.ls  = ls;
        t.exp.fs  = fs;
        t.exp.st  = 2'(st);
        t.exp.err = err;
        t.exp.fc  = 8'd0;
        return t;
    endfunction

    task automatic release_reset();
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        exp_q.push_back(reset_outs());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tab[23];
        outs_t none;
        int    hl[17];
        int    h, v;

        //            h    v    hs vs vid px   py   ls fs st err
        tab[0]  = mk(  0,   0,  1, 1, 1,   0,   0,  1, 1, 0, 0);
        tab[1]  = mk(  1,   0,  1, 1, 1,   1,   0,  0, 0, 0, 0);
        tab[2]  = mk(639,   0,  1, 1, 1, 639,   0,  0, 0, 0, 0);
        tab[3]  = mk(640,   0,  1, 1, 0,   0,   0,  0, 0, 0, 0);
        tab[4]  = mk(656,   0,  0, 1, 0,   0,   0,  0, 0, 0, 0);
        tab[5]  = mk(751,   0,  0, 1, 0,   0,   0,  0, 0, 0, 0);
        tab[6]  = mk(752,   0,  1, 1, 0,   0,   0,  0, 0, 0, 0);
        tab[7]  = mk(799,   0,  1, 1, 0,   0,   0,  0, 0, 0, 0);
        tab[8]  = mk(  0,   1,  1, 1, 1,   0,   1,  1, 0, 0, 0);
        tab[9]  = mk(  0, 300,  1, 1, 1,   0, 300,  1, 0, 0, 1);
        tab[10] = mk(  5, 300,  1, 1, 1,   5, 300,  0, 0, 0, 0);
        tab[11] = mk(  5, 491,  1, 0, 0,   0,   0,  0, 0, 2, 1);
        tab[12] = mk(  5, 492,  1, 1, 0,   0,   0,  0, 0, 3, 0);
        tab[13] = mk(800, 492,  1, 1, 0,   0,   0,  0, 0, 3, 1);
        tab[14] = mk(100, 525,  1, 1, 0,   0,   0,  0, 0, 3, 1);
        tab[15] = mk(799, 600,  1, 1, 0,   0,   0,  0, 0, 3, 1);
        tab[16] = mk(  0, 492,  1, 1, 0,   0,   0,  0, 0, 3, 0);
        tab[17] = mk(  0, 493,  1, 1, 0,   0,   0,  0, 0, 3, 0);
        tab[18] = mk(  0, 479,  1, 1, 1,   0, 479,  1, 0, 0, 1);
        tab[19] = mk(  0, 480,  1, 1, 0,   0,   0,  0, 0, 1, 0);
        tab[20] = mk(  0, 524,  1, 1, 0,   0,   0,  0, 0, 3, 1);
        tab[21] = mk(  0,   0,  1, 1, 1,   0,   0,  1, 1, 0, 0);
        tab[22] = mk(656, 490,  0, 0, 0,   0,   0,  0, 0, 2, 1);

        hl = '{0, 1, 2, 320, 638, 639, 640, 641, 655, 656, 657, 750, 751, 752, 753, 798, 799};
        none = '0;

        rst_n = 1'b0;
        h_in  = '0;
        v_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_values", reset_outs());

        @(negedge clk);
        release_reset();
        foreach (tab[i]) step(tab[i].h, tab[i].v, $sformatf("table[%0d]", i), 1'b1, tab[i].exp);

        // Mid-frame asynchronous reset, then resume from the middle of the screen
        step(320, 240, "pre_reset", 1'b0, none);
        rst_n = 1'b0;
        h_in  = 16'd321;
        #1;
        check("async_reset", reset_outs());
        @(posedge clk);
        #1;
        check("reset_held", reset_outs());
        @(negedge clk);
        release_reset();
        for (int x = 322; x < 340; x++) step(x, 240, "resume", 1'b0, none);
        step(0, 241, "resume_next_line", 1'b0, none);

        // Two frames: full lines around the boundaries, sparse columns elsewhere
        for (int f = 0; f < 2; f++) begin
            for (int vv = 0; vv < 525; vv++) begin
                if (vv < 2 || vv == 479 || vv == 480 || (vv >= 489 && vv <= 492) || vv == 524) begin
                    for (int hh = 0; hh < 800; hh++) step(hh, vv, "frame_full", 1'b0, none);
                end else begin
                    foreach (hl[k]) step(hl[k], vv, "frame_sparse", 1'b0, none);
                end
            end
        end

        // Randomized counts: mostly legal advance, with jumps and out-of-range bursts
        h = 0;
        v = 0;
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(99));
            if (r < 80) begin
                h += int'($urandom_range(1, 60));
                if (h >= 800) begin
                    h -= 800;
                    v = (v + 1) % 525;
                end
                step(h, v, "rand_run", 1'b0, none);
            end else if (r < 88) begin
                v = int'($urandom_range(524));
                step(h, v, "rand_vjump", 1'b0, none);
            end else if (r < 94) begin
                if ($urandom_range(1) == 0) step(int'($urandom_range(800, 1023)), v, "rand_h_oor", 1'b0, none);
                else                        step(h, int'($urandom_range(525, 1023)), "rand_v_oor", 1'b0, none);
            end else begin
                h = int'($urandom_range(799));
                step(h, v, "rand_hjump", 1'b0, none);
            end
        end
        step(h, v, "flush", 1'b0, none);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
